uart_program_loader: RTL and testbench



---
 rtl/pc_one_pkg.sv | 23 ++
 rtl/uart_program_loader_if.sv | 41 ++++
 rtl/loader_word_assembler.sv | 43 ++++
 rtl/uart_program_loader.sv | 172 +++++++++++++++++
 tb/tb_uart_program_loader.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_one_pkg.sv
// Shared definitions for the UART program loader.
//
// Contents:
//   loader_state_t  - loader FSM states, exported for debug and checkers
//   LOADER_MAGIC    - default start-of-image byte
//   HDR_LEN_BYTES   - length field size in bytes (little-endian word count)
//   WORD_BYTES      - bytes per memory word; also the address step per word
package pc_one_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } loader_state_t;

  localparam logic [7:0] LOADER_MAGIC  = 8'hA5;
  localparam int         HDR_LEN_BYTES = 4;
  localparam int         WORD_BYTES    = 4;

endpackage

// File: rtl/uart_program_loader_if.sv
// Byte-stream input and memory write port of the program loader.
//
// Signals:
//   rx_data   - received byte
//   rx_valid  - one-cycle strobe; rx_data is consumed only when high
//   mem_we    - one-cycle write strobe to instruction memory
//   mem_addr  - word-aligned byte address of the write
//   mem_wdata - write data word
//
// Handshake: rx_valid is a pure strobe with no back-pressure; the loader
// accepts a byte on every cycle rx_valid is high. mem_we is a pure strobe
// as well; memory is expected to accept the write in the cycle it is high.
//
// Modports:
//   master - the loader (consumes bytes, drives the write port)
//   slave  - the environment (UART receiver + instruction memory)
interface uart_program_loader_if;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    input  rx_data,
    input  rx_valid,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

endinterface

// File: rtl/loader_word_assembler.sv
// Collects four bytes into a 32-bit little-endian word.
//
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   sync_clr    - synchronous clear of byte counter and shift register
//   byte_valid  - a byte is presented on byte_in this cycle
//   byte_in     - the byte
//   word_valid  - high in the cycle the 4th byte of a word is presented
//   word        - the completed word, valid while word_valid is high
//
// word/word_valid are combinational from the current byte so the parent can
// register its write in the same edge that consumes the 4th byte.
module loader_word_assembler
  import pc_one_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sync_clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt;
  logic [31:0] shreg;

  // New bytes enter at the top; after four shifts the first byte sits in [7:0].
  assign word       = {byte_in, shreg[31:8]};
  assign word_valid = byte_valid && (byte_cnt == 2'(HDR_LEN_BYTES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || sync_clr) begin
      byte_cnt <= '0;
      shreg    <= '0;
    end else if (byte_valid) begin
      // Counter wraps to 0 after the 4th byte, ready for the next word.
      byte_cnt <= byte_cnt + 2'd1;
      shreg    <= word;
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Receives a program image from the UART byte stream and writes it into
// instruction memory, holding the CPU in reset until a verified image lands.
//
// Image: MAGIC, length N (4 bytes LE, in words), N*4 data bytes (each word
// LE), then one checksum byte = XOR of all data bytes.
//
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   bus         - rx byte strobe in, memory write port out (master modport)
//   cpu_hold    - high keeps the CPU in reset; drops only after a good image
//   busy        - high while an image is being received
//   load_done   - sticky: image loaded and checksum passed (terminal)
//   load_error  - sticky until the next MAGIC: image rejected
//   state       - current FSM state, for debug
//
// BASE_ADDR must be 4-byte aligned; it is added to 4*index unmodified.
module uart_program_loader
  import pc_one_pkg::*;
#(
  parameter int          WORDS          = 4096,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [7:0]  MAGIC          = LOADER_MAGIC,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_program_loader_if.master  bus,
  output logic                   cpu_hold,
  output logic                   busy,
  output logic                   load_done,
  output logic                   load_error,
  output loader_state_t          state
);

  localparam int IW = $clog2(WORDS) + 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Expiry fires on the edge where the idle count would reach TIMEOUT_CYCLES,
  // so load_error is visible exactly TIMEOUT_CYCLES cycles after the last byte.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [IW-1:0] idx;
  logic [31:0]   len_q;
  logic [7:0]    csum;
  logic [TW-1:0] tmo;

  logic          mem_we_q;
  logic [31:0]   mem_addr_q;
  logic [31:0]   mem_wdata_q;

  logic          asm_en;
  logic          asm_clr;
  logic          word_valid;
  logic [31:0]   word;
  logic          tmo_active;
  logic          last_word;

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // The assembler serves both the length field and the data words; it is
  // held clear in IDLE so every image starts on a byte-0 boundary.
  assign asm_en     = bus.rx_valid && ((state == LEN) || (state == DATA));
  assign asm_clr    = (state == IDLE);
  assign tmo_active = (state == LEN) || (state == DATA) || (state == CSUM);
  assign last_word  = ((32'(idx) + 32'd1) == len_q);

  loader_word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync_clr   (asm_clr),
    .byte_valid (asm_en),
    .byte_in    (bus.rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
      cpu_hold    <= 1'b1;
      busy        <= 1'b0;
      load_done   <= 1'b0;
      load_error  <= 1'b0;
      idx         <= '0;
      len_q       <= '0;
      csum        <= '0;
      tmo         <= '0;
    end else begin
      mem_we_q <= 1'b0;

      // Idle-gap watchdog. Byte-driven transitions below only happen with
      // rx_valid high, so they never collide with the expiry path.
      if (tmo_active && !bus.rx_valid) begin
        tmo <= tmo + TW'(1);
        if (tmo == TMO_LAST) begin
          state      <= ERROR;
          load_error <= 1'b1;
          busy       <= 1'b0;
        end
      end else begin
        tmo <= '0;
      end

      case (state)
        IDLE: begin
          if (bus.rx_valid && (bus.rx_data == MAGIC)) begin
            state      <= LEN;
            busy       <= 1'b1;
            load_error <= 1'b0;
            idx        <= '0;
            csum       <= '0;
          end
        end

        LEN: begin
          if (word_valid) begin
            len_q <= word;
            if ((word == 32'd0) || (word > 32'(WORDS))) begin
              state      <= ERROR;
              load_error <= 1'b1;
              busy       <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (bus.rx_valid) begin
            csum <= csum ^ bus.rx_data;
          end
          if (word_valid) begin
            mem_we_q    <= 1'b1;
            mem_wdata_q <= word;
            mem_addr_q  <= BASE_ADDR + (32'(idx) * 32'(WORD_BYTES));
            idx         <= idx + IW'(1);
            if (last_word) begin
              state <= CSUM;
            end
          end
        end

        CSUM: begin
          if (bus.rx_valid) begin
            busy <= 1'b0;
            if (bus.rx_data == csum) begin
              state     <= DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
            end
          end
        end

        // Terminal until reset; bytes are ignored.
        DONE: ;

        // load_error/busy were set on entry; just return to hunting for MAGIC.
        ERROR: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
module tb_uart_program_loader;
  import pc_one_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cpu_hold;
  logic          busy;
  logic          load_done;
  logic          load_error;
  loader_state_t dut_state;

  uart_program_loader_if bus ();

  uart_program_loader #(
    .WORDS          (4096),
    .BASE_ADDR      (32'h0000_0000),
    .MAGIC          (8'hA5),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .load_done  (load_done),
    .load_error (load_error),
    .state      (dut_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- scoreboard queues ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] got_data_q[$];
  logic [31:0] got_addr_q[$];

  // Capture every write strobe, sampled 1 time unit after the active edge.
  always begin
    @(posedge clk);
    #1;
    if (bus.mem_we === 1'b1) begin
      got_addr_q.push_back(bus.mem_addr);
      got_data_q.push_back(bus.mem_wdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_header(input logic [31:0] n);
    send_byte(8'hA5);
    send_word(n);
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_q.push_back(d);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    got_addr_q.delete();
    got_data_q.delete();
    exp_addr_q.delete();
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    do_reset();
    n_checks++;
    if (dut_state !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", int'(dut_state), int'(IDLE)); end
    n_checks++;
    if ({bus.mem_we, busy, load_done, load_error, cpu_hold} !== 5'b00001) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=00001", {bus.mem_we, busy, load_done, load_error, cpu_hold});
    end
    n_checks++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus got addr=%h data=%h exp 0/0", bus.mem_addr, bus.mem_wdata);
    end
  endtask

  task automatic test_nominal;
    do_reset();
    send_byte(8'hA5);
    n_checks++;
    if (dut_state !== LEN || busy !== 1'b1) begin
      n_fail++; $display("FAIL nom_magic got state=%0d busy=%b exp state=1 busy=1", int'(dut_state), busy);
    end
    send_word(32'd2);
    send_word(32'h0000_0013);
    send_word(32'h0000_006F);
    expect_write(32'h0, 32'h0000_0013);
    expect_write(32'h4, 32'h0000_006F);
    n_checks++;
    if (dut_state !== CSUM) begin n_fail++; $display("FAIL nom_csum_state got=%0d exp=%0d", int'(dut_state), int'(CSUM)); end
    send_byte(8'h7C);
    @(negedge clk);
    n_checks++;
    if (got_addr_q.size() != exp_addr_q.size()) begin
      n_fail++; $display("FAIL nom_wr_count got=%0d exp=%0d", got_addr_q.size(), exp_addr_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_data_q.size(); i++) begin
      n_checks++;
      if (got_addr_q[i] !== exp_addr_q[i] || got_data_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL nom_wr%0d got %h:%h exp %h:%h", i, got_addr_q[i], got_data_q[i], exp_addr_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if ({load_done, cpu_hold, load_error, busy} !== 4'b1000 || dut_state !== DONE) begin
      n_fail++; $display("FAIL nom_done got done/hold/err/busy=%b state=%0d exp 1000 state=4",
                         {load_done, cpu_hold, load_error, busy}, int'(dut_state));
    end
  endtask

  task automatic test_bad_csum;
    do_reset();
    send_header(32'd2);
    send_word(32'h0000_0013);
    send_word(32'h0000_006F);
    send_byte(8'h00);
    n_checks++;
    if (dut_state !== ERROR || load_error !== 1'b1) begin
      n_fail++; $display("FAIL bad_err got state=%0d err=%b exp state=5 err=1", int'(dut_state), load_error);
    end
    @(negedge clk);
    n_checks++;
    if (dut_state !== IDLE || {load_error, cpu_hold, busy, load_done} !== 4'b1100) begin
      n_fail++; $display("FAIL bad_idle got state=%0d err/hold/busy/done=%b exp state=0 1100",
                         int'(dut_state), {load_error, cpu_hold, busy, load_done});
    end
    n_checks++;
    if (got_addr_q.size() != 2) begin
      n_fail++; $display("FAIL bad_wr_count got=%0d exp=2", got_addr_q.size());
    end else begin
      n_checks++;
      if (got_data_q[0] !== 32'h13 || got_data_q[1] !== 32'h6F || got_addr_q[1] !== 32'h4) begin
        n_fail++; $display("FAIL bad_wr_data got %h %h @%h exp 13 6f @4", got_data_q[0], got_data_q[1], got_addr_q[1]);
      end
    end
    send_byte(8'hA5);
    n_checks++;
    if (load_error !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL bad_retry_clear got err=%b busy=%b exp err=0 busy=1", load_error, busy);
    end
    send_word(32'd2);
    send_word(32'h0000_0013);
    send_word(32'h0000_006F);
    send_byte(8'h7C);
    n_checks++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b0 || got_addr_q.size() != 4) begin
      n_fail++; $display("FAIL bad_retry_done got done=%b hold=%b writes=%0d exp 1 0 4", load_done, cpu_hold, got_addr_q.size());
    end
  endtask

  task automatic test_len_bounds;
    logic [31:0] w;
    logic [7:0]  ck;
    int          bad;
    int          first_bad;
    do_reset();
    send_header(32'd0);
    n_checks++;
    if (dut_state !== ERROR || load_error !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL len0 got state=%0d err=%b busy=%b exp 5 1 0", int'(dut_state), load_error, busy);
    end
    @(negedge clk);
    send_header(32'd4097);
    n_checks++;
    if (dut_state !== ERROR || load_error !== 1'b1) begin
      n_fail++; $display("FAIL len4097 got state=%0d err=%b exp 5 1", int'(dut_state), load_error);
    end
    @(negedge clk);
    n_checks++;
    if (got_addr_q.size() != 0) begin n_fail++; $display("FAIL len_bad_writes got=%0d exp=0", got_addr_q.size()); end

    // Full-depth image.
    ck = 8'h00;
    send_header(32'd4096);
    for (int i = 0; i < 4096; i++) begin
      w = {16'(i), ~16'(i)};
      ck = ck ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      expect_write(32'(i) * 32'd4, w);
      send_word(w);
    end
    send_byte(ck);
    @(negedge clk);
    n_checks++;
    if (got_addr_q.size() != 4096) begin
      n_fail++; $display("FAIL full_wr_count got=%0d exp=4096", got_addr_q.size());
    end else begin
      n_checks++;
      if (got_addr_q[4095] !== 32'h0000_3FFC) begin
        n_fail++; $display("FAIL full_last_addr got=%h exp=00003ffc", got_addr_q[4095]);
      end
      bad = 0;
      first_bad = -1;
      for (int i = 0; i < 4096; i++) begin
        if (got_addr_q[i] !== exp_addr_q[i] || got_data_q[i] !== exp_q[i]) begin
          if (first_bad < 0) first_bad = i;
          bad++;
        end
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++; $display("FAIL full_data got %0d bad words (first at %0d) exp 0", bad, first_bad);
      end
    end
    n_checks++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b0) begin
      n_fail++; $display("FAIL full_done got done=%b hold=%b exp 1 0", load_done, cpu_hold);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h00);
    // Now at the negedge following the edge that took the last byte.
    for (int i = 0; i < 99; i++) @(negedge clk);
    n_checks++;
    if (load_error !== 1'b0 || dut_state !== LEN) begin
      n_fail++; $display("FAIL tmo_early got err=%b state=%0d at 99 cycles exp 0 1", load_error, int'(dut_state));
    end
    @(negedge clk);
    n_checks++;
    if (load_error !== 1'b1 || dut_state !== ERROR || busy !== 1'b0 || cpu_hold !== 1'b1) begin
      n_fail++; $display("FAIL tmo_fire got err=%b state=%0d busy=%b hold=%b at 100 cycles exp 1 5 0 1",
                         load_error, int'(dut_state), busy, cpu_hold);
    end
  endtask

  task automatic test_noise_ignore;
    logic [7:0] noise[3];
    noise[0] = 8'h00; noise[1] = 8'hFF; noise[2] = 8'h5A;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_byte(noise[i]);
      n_checks++;
      if (dut_state !== IDLE || busy !== 1'b0) begin
        n_fail++; $display("FAIL noise%0d got state=%0d busy=%b exp 0 0", i, int'(dut_state), busy);
      end
    end
    send_header(32'd2);
    send_word(32'h0000_0013);
    send_word(32'h0000_006F);
    send_byte(8'h7C);
    n_checks++;
    if (load_done !== 1'b1 || got_addr_q.size() != 2) begin
      n_fail++; $display("FAIL noise_load got done=%b writes=%0d exp 1 2", load_done, got_addr_q.size());
    end
    send_header(32'd1);
    send_word(32'hDEAD_BEEF);
    send_byte(8'h22);
    @(negedge clk);
    n_checks++;
    if (got_addr_q.size() != 2 || dut_state !== DONE || cpu_hold !== 1'b0 || load_error !== 1'b0) begin
      n_fail++; $display("FAIL after_done got writes=%0d state=%0d hold=%b err=%b exp 2 4 0 0",
                         got_addr_q.size(), int'(dut_state), cpu_hold, load_error);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    send_header(32'd3);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    send_byte(8'h33);
    send_byte(8'h33);
    n_checks++;
    if (bus.mem_addr !== 32'h4 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre got addr=%h busy=%b exp 4 1", bus.mem_addr, busy);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (cpu_hold !== 1'b1 || busy !== 1'b0 || bus.mem_addr !== 32'h0 || dut_state !== IDLE) begin
      n_fail++; $display("FAIL mid_rst got hold=%b busy=%b addr=%h state=%0d exp 1 0 0 0",
                         cpu_hold, busy, bus.mem_addr, int'(dut_state));
    end
    got_addr_q.delete();
    got_data_q.delete();
    send_header(32'd2);
    send_word(32'h0000_0013);
    send_word(32'h0000_006F);
    send_byte(8'h7C);
    @(negedge clk);
    n_checks++;
    if (got_addr_q.size() != 2) begin
      n_fail++; $display("FAIL mid_reload_count got=%0d exp=2", got_addr_q.size());
    end else begin
      n_checks++;
      if (got_addr_q[0] !== 32'h0 || got_data_q[0] !== 32'h13 || got_addr_q[1] !== 32'h4 || got_data_q[1] !== 32'h6F) begin
        n_fail++; $display("FAIL mid_reload got %h:%h %h:%h exp 0:13 4:6f",
                           got_addr_q[0], got_data_q[0], got_addr_q[1], got_data_q[1]);
      end
    end
    n_checks++;
    if (load_done !== 1'b1) begin n_fail++; $display("FAIL mid_reload_done got=%b exp=1", load_done); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    test_reset();
    test_nominal();
    test_bad_csum();
    test_len_bounds();
    test_timeout();
    test_noise_ignore();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    n_fail++;
    $display("FAIL watchdog got no completion within 5ms exp completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
